// File: rtl/sio_deframer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sio_deframer
// Receive back end of the SIO link. Collects the recovered symbol stream from
// the data-recovery unit into NB-bit frames, optionally checks a trailing
// CRC-8 (poly 0x07, init 0x00, MSB first, over the payload only), aborts a
// frame when the gap between symbols grows too long, and keeps saturating
// good-frame / error-frame counters.
//
// Ports
//   c        clock
//   r        asynchronous active-high reset
//   arm      re-arm level; moves HOLD to IDLE, aborts a frame in progress
//   i_d      received symbol (LW bits, oldest bit in MSB)
//   i_v      symbol valid qualifier
//   d        last good frame payload, first symbol in the MSBs
//   v        one-cycle frame-complete pulse
//   crc_err  one-cycle pulse with v when the received CRC mismatches
//   tmo_err  one-cycle pulse when a frame is dropped by the gap timeout
//   busy     frame assembly in progress (DATA or CRC state)
//   n_frm    saturating good-frame count
//   n_err    saturating errored-frame count (CRC + timeout)
// ---------------------------------------------------------------------------
module sio_deframer #(
    parameter int NB     = 32,
    parameter int LW     = 4,
    parameter int CRC_EN = 1,
    parameter int TMO    = 15
) (
    input  logic          c,
    input  logic          r,
    input  logic          arm,
    input  logic [LW-1:0] i_d,
    input  logic          i_v,
    output logic [NB-1:0] d,
    output logic          v,
    output logic          crc_err,
    output logic          tmo_err,
    output logic          busy,
    output logic [15:0]   n_frm,
    output logic [15:0]   n_err
);

    localparam int NSYM = NB / LW;
    localparam int CSYM = 8 / LW;
    // Wide enough for both the payload and the CRC symbol index.
    localparam int CW   = $clog2(NSYM + 8);
    localparam logic [CW-1:0] LAST_D  = CW'(NSYM - 1);
    localparam logic [CW-1:0] LAST_C  = CW'(CSYM - 1);
    localparam logic [7:0]    GAP_LIM = 8'(TMO - 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_IDLE = 2'd1,
        ST_DATA = 2'd2,
        ST_CRC  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [NB-1:0]   r_shift, w_shift_nx, w_shift_full, w_payload;
    logic [7:0]      r_rcrc, w_rcrc_nx, w_rcrc_full;
    logic [7:0]      r_crc, w_crc_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [7:0]      r_gap, w_gap_nx;
    logic [NB-1:0]   r_d, w_d_nx;
    logic            r_v, w_v_nx;
    logic            r_crc_err, w_crc_err_nx;
    logic            r_tmo_err, w_tmo_err_nx;
    logic            r_busy;
    logic [15:0]     r_n_frm, w_n_frm_nx;
    logic [15:0]     r_n_err, w_n_err_nx;
    logic            w_frm_inc, w_err_inc;
    logic            w_frame_end, w_crc_bad;

    // CRC-8 (poly 0x07) advanced over one symbol, MSB first.
    function automatic logic [7:0] crc8_sym(input logic [7:0] crc_in, input logic [LW-1:0] sym);
        logic [7:0] crc_v;
        logic       fb;
        crc_v = crc_in;
        for (int i = LW - 1; i >= 0; i--) begin
            fb    = crc_v[7] ^ sym[i];
            crc_v = {crc_v[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return crc_v;
    endfunction

    // Shift-register views with the current symbol appended.
    assign w_shift_full = NB'({r_shift, i_d});
    assign w_rcrc_full  = 8'({r_rcrc, i_d});
    // Without CRC the frame ends on the last payload symbol, so the payload
    // must include the symbol arriving this cycle.
    assign w_payload    = (CRC_EN != 0) ? r_shift : w_shift_full;
    assign w_crc_bad    = (CRC_EN != 0) && (w_rcrc_full != r_crc);
    assign w_frame_end  = (r_state == ST_DATA) ? ((CRC_EN == 0) && (r_cnt == LAST_D))
                                               : (r_cnt == LAST_C);

    // Next-state and datapath decode.
    always_comb begin
        w_state_nx   = r_state;
        w_shift_nx   = r_shift;
        w_rcrc_nx    = r_rcrc;
        w_crc_nx     = r_crc;
        w_cnt_nx     = r_cnt;
        w_gap_nx     = r_gap;
        w_d_nx       = r_d;
        w_v_nx       = 1'b0;
        w_crc_err_nx = 1'b0;
        w_tmo_err_nx = 1'b0;
        w_frm_inc    = 1'b0;
        w_err_inc    = 1'b0;
        case (r_state)
            ST_HOLD: begin
                if (arm) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_HOLD;
                end
            end
            ST_IDLE: begin
                if (i_v) begin
                    w_state_nx = ST_DATA;
                    w_shift_nx = {{(NB-LW){1'b0}}, i_d};
                    w_rcrc_nx  = 8'h00;
                    w_crc_nx   = crc8_sym(8'h00, i_d);
                    w_cnt_nx   = CW'(1);
                    w_gap_nx   = 8'h00;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_DATA, ST_CRC: begin
                if (i_v && w_frame_end) begin
                    // Frame completes even if arm is high; arm only picks IDLE over HOLD.
                    w_v_nx     = 1'b1;
                    w_gap_nx   = 8'h00;
                    w_state_nx = arm ? ST_IDLE : ST_HOLD;
                    if (w_crc_bad) begin
                        w_crc_err_nx = 1'b1;
                        w_err_inc    = 1'b1;
                    end else begin
                        w_d_nx    = w_payload;
                        w_frm_inc = 1'b1;
                    end
                end else if (arm) begin
                    w_state_nx = ST_IDLE;
                    w_gap_nx   = 8'h00;
                end else if (i_v) begin
                    w_gap_nx = 8'h00;
                    w_cnt_nx = r_cnt + CW'(1);
                    if (r_state == ST_DATA) begin
                        w_shift_nx = w_shift_full;
                        w_crc_nx   = crc8_sym(r_crc, i_d);
                        if (r_cnt == LAST_D) begin
                            w_state_nx = ST_CRC;
                            w_cnt_nx   = {CW{1'b0}};
                        end else begin
                            w_state_nx = ST_DATA;
                        end
                    end else begin
                        w_rcrc_nx = w_rcrc_full;
                    end
                end else if (r_gap == GAP_LIM) begin
                    // TMO-th consecutive idle cycle: drop the partial frame.
                    w_tmo_err_nx = 1'b1;
                    w_err_inc    = 1'b1;
                    w_gap_nx     = 8'h00;
                    w_state_nx   = ST_HOLD;
                end else begin
                    w_gap_nx = r_gap + 8'h01;
                end
            end
            default: begin
                w_state_nx = ST_HOLD;
            end
        endcase
    end

    // Saturating counter next values.
    always_comb begin
        w_n_frm_nx = r_n_frm;
        w_n_err_nx = r_n_err;
        if (w_frm_inc && (r_n_frm != 16'hFFFF)) begin
            w_n_frm_nx = r_n_frm + 16'h0001;
        end else begin
            w_n_frm_nx = r_n_frm;
        end
        if (w_err_inc && (r_n_err != 16'hFFFF)) begin
            w_n_err_nx = r_n_err + 16'h0001;
        end else begin
            w_n_err_nx = r_n_err;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            r_state   <= ST_HOLD;
            r_shift   <= {NB{1'b0}};
            r_rcrc    <= 8'h00;
            r_crc     <= 8'h00;
            r_cnt     <= {CW{1'b0}};
            r_gap     <= 8'h00;
            r_d       <= {NB{1'b0}};
            r_v       <= 1'b0;
            r_crc_err <= 1'b0;
            r_tmo_err <= 1'b0;
            r_busy    <= 1'b0;
            r_n_frm   <= 16'h0000;
            r_n_err   <= 16'h0000;
        end else begin
            r_state   <= w_state_nx;
            r_shift   <= w_shift_nx;
            r_rcrc    <= w_rcrc_nx;
            r_crc     <= w_crc_nx;
            r_cnt     <= w_cnt_nx;
            r_gap     <= w_gap_nx;
            r_d       <= w_d_nx;
            r_v       <= w_v_nx;
            r_crc_err <= w_crc_err_nx;
            r_tmo_err <= w_tmo_err_nx;
            r_busy    <= (w_state_nx == ST_DATA) || (w_state_nx == ST_CRC);
            r_n_frm   <= w_n_frm_nx;
            r_n_err   <= w_n_err_nx;
        end
    end

    assign d       = r_d;
    assign v       = r_v;
    assign crc_err = r_crc_err;
    assign tmo_err = r_tmo_err;
    assign busy    = r_busy;
    assign n_frm   = r_n_frm;
    assign n_err   = r_n_err;

endmodule
